tcdm_req_arbiter: RTL

- Request-side arbiter for one TCDM bank.
- Sits directly upstream of the bank's response demultiplexer.
- Selects one of NUM_INPUTS master requests round-robin and forwards it to the bank.
- Drives the winning master index to the response demux, and allows at most one outstanding read so that the demux's single service index is never overwritten before its response completes.

---
 rtl/tcdm_req_arbiter_if.sv | 39 +++
 rtl/tcdm_req_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/tcdm_req_arbiter_if.sv
// rtl/tcdm_req_arbiter_if.sv - master request, bank and response-handshake bundle for tcdm_req_arbiter
interface tcdm_req_arbiter_if #(
  parameter int NUM_INPUTS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = $clog2(NUM_INPUTS);

  // master side
  logic [NUM_INPUTS-1:0]                   req_i;
  logic [NUM_INPUTS-1:0]                   wen_i;
  logic [NUM_INPUTS-1:0][ADDR_WIDTH-1:0]   addr_i;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]   wdata_i;
  logic [NUM_INPUTS-1:0][DATA_WIDTH/8-1:0] be_i;
  logic [NUM_INPUTS-1:0]                   gnt_o;

  // bank side
  logic                    req_o;
  logic                    wen_o;
  logic [ADDR_WIDTH-1:0]   addr_o;
  logic [DATA_WIDTH-1:0]   wdata_o;
  logic [DATA_WIDTH/8-1:0] be_o;
  logic                    gnt_i;

  // response demux side
  logic [IDX_W-1:0] master_idx_o;
  logic             rvalid_i;
  logic             rready_i;

  modport slave (
    input  req_i, wen_i, addr_i, wdata_i, be_i, gnt_i, rvalid_i, rready_i,
    output gnt_o, req_o, wen_o, addr_o, wdata_o, be_o, master_idx_o
  );

  modport master (
    output req_i, wen_i, addr_i, wdata_i, be_i, gnt_i, rvalid_i, rready_i,
    input  gnt_o, req_o, wen_o, addr_o, wdata_o, be_o, master_idx_o
  );
endinterface

// File: rtl/tcdm_req_arbiter.sv
// rtl/tcdm_req_arbiter.sv - round-robin TCDM bank request arbiter, one outstanding read; starvation guard via TCDM_REQ_ARB_STARVE_GUARD_EN
module tcdm_req_arbiter #(
  parameter int NUM_INPUTS   = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 15
) (
  input logic               clk_i,
  input logic               rst_i,
  tcdm_req_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_INPUTS-1);

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      rr_sel;
  logic [IDX_W-1:0]      sel;
  logic                  rd_pending;
  logic                  rd_done;
  logic                  sel_valid;
  logic                  hs;
  logic                  sel_wen;
  logic [NUM_INPUTS-1:0] elig;
  logic [NUM_INPUTS-1:0] gnt;

  // A read may only issue when no read is outstanding, or in the cycle the outstanding one retires
  assign rd_done   = bus.rvalid_i & bus.rready_i & rd_pending;
  assign elig      = bus.req_i & (bus.wen_i | {NUM_INPUTS{~rd_pending | rd_done}});
  assign sel_valid = |elig;
  assign hs        = sel_valid & bus.gnt_i;

  // First eligible master scanning from rr_ptr with wrap
  always_comb begin
    logic [IDX_W:0] pos;
    logic           found;
    rr_sel = '0;
    pos    = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (pos >= N_EXT) pos = pos - N_EXT;
      if (!found && elig[pos[IDX_W-1:0]]) begin
        rr_sel = pos[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

`ifdef TCDM_REQ_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [NUM_INPUTS-1:0][CNT_W-1:0] wait_cnt;

  // Lowest-index eligible master at the wait limit overrides round-robin order
  always_comb begin
    sel = rr_sel;
    for (int k = NUM_INPUTS-1; k >= 0; k--) begin
      if (elig[k] && (wait_cnt[k] == CNT_MAX)) sel = IDX_W'(k);
    end
  end

  // Per-master wait counters: count ungranted request cycles, saturating
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (bus.req_i[k] && !gnt[k]) begin
          if (wait_cnt[k] != CNT_MAX) wait_cnt[k] <= wait_cnt[k] + CNT_W'(1);
        end else begin
          wait_cnt[k] <= '0;
        end
      end
    end
  end
`else
  logic unused_starve;
  assign unused_starve = ^STARVE_LIMIT;
  assign sel = rr_sel;
`endif

  // Forward the winner's request fields, zero when nobody is selected
  always_comb begin
    bus.wen_o        = 1'b0;
    bus.addr_o       = '0;
    bus.wdata_o      = '0;
    bus.be_o         = '0;
    bus.master_idx_o = '0;
    if (sel_valid) begin
      bus.wen_o        = bus.wen_i[sel];
      bus.addr_o       = bus.addr_i[sel];
      bus.wdata_o      = bus.wdata_i[sel];
      bus.be_o         = bus.be_i[sel];
      bus.master_idx_o = sel;
    end
  end

  // Grant passes the bank grant straight through to the selected master
  always_comb begin
    gnt = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      gnt[k] = bus.gnt_i & sel_valid & (sel == IDX_W'(k));
    end
  end

  assign sel_wen   = sel_valid & bus.wen_i[sel];
  assign bus.gnt_o = gnt;
  assign bus.req_o = sel_valid;

  // Round-robin pointer advances past the winner on handshake; track the single outstanding read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      rd_pending <= 1'b0;
    end else begin
      if (hs) rr_ptr <= (sel == LAST) ? '0 : sel + IDX_W'(1);
      if (hs && !sel_wen)  rd_pending <= 1'b1;
      else if (rd_done)    rd_pending <= 1'b0;
    end
  end
endmodule
